// File: rtl/nor_sweep.sv
// rtl/nor_sweep.sv - exhaustive 16-vector sweep of a three-stage NOR chain with mismatch tally
// Drives a..d from a 4-bit vector, waits SETTLE_CYC cycles, then checks e,f,g against the ideal chain.
module nor_sweep #(
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYC);

  state_t     state;
  logic [3:0] vec;
  logic [3:0] cnt;
  logic       first_seen;
  logic       ee;
  logic       ef;
  logic       eg;
  logic       mismatch;

  // a..d trail vec by one cycle; at least one SETTLE edge always separates them from CHECK
  always_comb begin
    ee       = ~(vec[3] | vec[2]);
    ef       = ~(ee | vec[1]);
    eg       = ~(ef | vec[0]);
    mismatch = ({e, f, g} != {ee, ef, eg});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 4'd0;
      cnt        <= 4'd0;
      first_seen <= 1'b0;
      {a, b, c, d} <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 5'd0;
      fail_vec   <= 4'd0;
    end else begin
      {a, b, c, d} <= vec;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec        <= 4'd0;
            cnt        <= RELOAD;
            err_cnt    <= 5'd0;
            fail_vec   <= 4'd0;
            pass       <= 1'b0;
            first_seen <= 1'b0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 5'd1;
            if (!first_seen) begin
              fail_vec   <= vec;
              first_seen <= 1'b1;
            end
          end
          if (vec == 4'd15) begin
            state <= DONE;
          end else begin
            vec   <= vec + 4'd1;
            cnt   <= RELOAD;
            state <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (err_cnt == 5'd0);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_sweep.sv
// tb/tb_nor_sweep.sv - scoreboard bench for nor_sweep with SETTLE_CYC=1 and SETTLE_CYC=3 instances
module tb_nor_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start_drv = 1'b0;
  int         sel = 0;
  int         fault = 0;
  logic       start0, a0, b0, c0, d0, e0, f0, g0, busy0, done0, pass0;
  logic       start1, a1, b1, c1, d1, e1, f1, g1, busy1, done1, pass1;
  logic [4:0] err0, err1;
  logic [3:0] fv0, fv1;

  // fault 0: ideal chain, 1: g stuck low, 2: first stage is OR instead of NOR
  function automatic logic [2:0] chain(input logic [3:0] v, input int flt);
    logic xe, xf, xg;
    xe = (flt == 2) ? (v[3] | v[2]) : ~(v[3] | v[2]);
    xf = ~(xe | v[1]);
    xg = (flt == 1) ? 1'b0 : ~(xf | v[0]);
    return {xe, xf, xg};
  endfunction

  assign {e0, f0, g0} = chain({a0, b0, c0, d0}, fault);
  assign {e1, f1, g1} = chain({a1, b1, c1, d1}, fault);
  assign start0 = start_drv & (sel == 0);
  assign start1 = start_drv & (sel == 1);

  nor_sweep #(.SETTLE_CYC(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .c(c0), .d(d0),
    .e(e0), .f(f0), .g(g0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_vec(fv0)
  );

  nor_sweep #(.SETTLE_CYC(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1), .d(d1),
    .e(e1), .f(f1), .g(g1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fv1)
  );

  logic       o_busy, o_done, o_pass;
  logic [4:0] o_err;
  logic [3:0] o_fv, o_vec;
  always_comb begin
    o_busy = busy0; o_done = done0; o_pass = pass0;
    o_err  = err0;  o_fv   = fv0;   o_vec  = {a0, b0, c0, d0};
    if (sel == 1) begin
      o_busy = busy1; o_done = done1; o_pass = pass1;
      o_err  = err1;  o_fv   = fv1;   o_vec  = {a1, b1, c1, d1};
    end
  end

  typedef struct {
    int         lat;
    logic       pass;
    logic [4:0] err;
    logic [3:0] fv;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input int flt, input int s);
    exp_t       x;
    int         n;
    logic [3:0] first;
    n = 0;
    first = 4'd0;
    for (int v = 0; v < 16; v++) begin
      if (chain(4'(v), flt) != chain(4'(v), 0)) begin
        if (n == 0) first = 4'(v);
        n++;
      end
    end
    x.lat  = 16 * (s + 1) + 1;
    x.pass = (n == 0);
    x.err  = 5'(n);
    x.fv   = first;
    sbq.push_back(x);
  endtask

  task automatic run_sweep(input int flt, input int s, input bit repulse);
    exp_t x;
    int   n;
    bit   got;
    fault = flt;
    push_expect(flt, s);
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    vectors++;
    if (o_busy !== 1'b1 || o_pass !== 1'b0 || o_err !== 5'd0 || o_fv !== 4'd0) begin
      miscompares++;
      $display("FAIL accept: busy=%0b pass=%0b err=%0d fv=%0d, required 1 0 0 0", o_busy, o_pass, o_err, o_fv);
    end
    n = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      if (repulse && (n == 10 || n == 16 * (s + 1))) start_drv = 1'b1;
      tick();
      start_drv = 1'b0;
      n++;
      if (o_done === 1'b1) begin
        got = 1'b1;
      end else if (n <= 16 * (s + 1)) begin
        vectors++;
        if (o_vec !== 4'((n - 1) / (s + 1))) begin
          miscompares++;
          $display("FAIL stim_vec cycle %0d: got %0d required %0d", n, o_vec, (n - 1) / (s + 1));
        end
      end
    end
    x = sbq.pop_front();
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles, required at %0d", n, x.lat);
    end else begin
      if (n != x.lat) begin
        miscompares++;
        $display("FAIL latency: got %0d required %0d", n, x.lat);
      end
      vectors++;
      if (o_pass !== x.pass || o_err !== x.err || o_fv !== x.fv || o_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL result: pass=%0b err=%0d fv=%0d busy=%0b, required %0b %0d %0d 0",
                 o_pass, o_err, o_fv, o_busy, x.pass, x.err, x.fv);
      end
    end
  endtask

  task automatic check_idle_hold(input string tag, input logic xp, input logic [4:0] xe, input logic [3:0] xf);
    tick();
    vectors++;
    if (o_done !== 1'b0 || o_pass !== xp || o_err !== xe || o_fv !== xf || o_vec !== 4'd15) begin
      miscompares++;
      $display("FAIL %s_hold: done=%0b pass=%0b err=%0d fv=%0d vec=%0d, required 0 %0b %0d %0d 15",
               tag, o_done, o_pass, o_err, o_fv, o_vec, xp, xe, xf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sel = i;
      #0;
      vectors++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 || o_err !== 5'd0 || o_fv !== 4'd0 || o_vec !== 4'd0) begin
        miscompares++;
        $display("FAIL reset inst%0d: busy=%0b done=%0b pass=%0b err=%0d fv=%0d vec=%0d, required all 0",
                 i, o_busy, o_done, o_pass, o_err, o_fv, o_vec);
      end
    end
    sel = 0;
  endtask

  task automatic test_correct();
    sel = 0;
    run_sweep(0, 1, 1'b0);
    check_idle_hold("correct", 1'b1, 5'd0, 4'd0);
  endtask

  task automatic test_g_stuck();
    sel = 0;
    run_sweep(1, 1, 1'b0);
    check_idle_hold("g_stuck", 1'b0, 5'd5, 4'd0);
  endtask

  task automatic test_e_inverted();
    sel = 0;
    run_sweep(2, 1, 1'b0);
    check_idle_hold("e_inv", 1'b0, 5'd16, 4'd0);
  endtask

  task automatic test_reset_mid();
    int n;
    sel = 0;
    fault = 1;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    n = 0;
    while (n < 100 && o_vec !== 4'd7) begin
      tick();
      n++;
    end
    vectors++;
    if (o_vec !== 4'd7 || o_err !== 5'd3) begin
      miscompares++;
      $display("FAIL pre_reset: vec=%0d err=%0d, required 7 3", o_vec, o_err);
    end
    rst = 1'b1;
    start_drv = 1'b1;
    tick();
    rst = 1'b0;
    start_drv = 1'b0;
    vectors++;
    if (o_busy !== 1'b0 || o_vec !== 4'd0 || o_err !== 5'd0 || o_done !== 1'b0 || o_fv !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%0b vec=%0d err=%0d done=%0b fv=%0d, required 0 0 0 0 0",
               o_busy, o_vec, o_err, o_done, o_fv);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      vectors++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abandoned cycle %0d: done=%0b busy=%0b, required 0 0", i, o_done, o_busy);
      end
    end
    run_sweep(0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    run_sweep(1, 1, 1'b1);
    run_sweep(0, 1, 1'b0);
    check_idle_hold("b2b", 1'b1, 5'd0, 4'd0);
  endtask

  task automatic test_settle3();
    sel = 1;
    run_sweep(0, 3, 1'b0);
    check_idle_hold("settle3", 1'b1, 5'd0, 4'd0);
    run_sweep(2, 3, 1'b0);
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_g_stuck();
    test_e_inverted();
    test_reset_mid();
    test_back_to_back();
    test_settle3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nor_sweep.md
NOR_SWEEP -- requirements
Module: nor_sweep

Interface
REQ-001 Parameter SETTLE_CYC, default 1, settle cycles per vector before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle run request; sampled only in IDLE.
REQ-005 a, b, c, d  output  1 each  stimulus to the three-stage NOR chain; a=vec[3], b=vec[2], c=vec[1], d=vec[0].
REQ-006 e, f, g  input  1 each  chain responses to be checked.
REQ-007 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-008 done  output  1  one-cycle pulse at end of sweep.
REQ-009 pass  output  1  high when the last completed sweep had zero mismatches; held until next accepted start.
REQ-010 err_cnt  output  5  mismatching vectors in current or last sweep, 0..16.
REQ-011 fail_vec  output  4  first mismatching vector; 0 if none.

Function
REQ-012 FSM states: IDLE, SETTLE, CHECK, DONE; one-hot or binary is implementer's choice.
REQ-013 IDLE and start=1: vec<=0, settle counter<=SETTLE_CYC, err_cnt<=0, fail_vec<=0, pass<=0, first-fail flag cleared, next state SETTLE.
REQ-014 a..d SHALL be registered directly from vec; no combinational path from start to a..d.
REQ-015 SETTLE: counter decrements each cycle; on the cycle it reads 1, next state CHECK.
REQ-016 CHECK: expected ee=~(a|b), ef=~(ee|c), eg=~(ef|d) computed from vec; mismatch when {e,f,g}!={ee,ef,eg}.
REQ-017 On mismatch, err_cnt increments; if first mismatch of the sweep, fail_vec<=vec and first-fail flag set.
REQ-018 CHECK with vec!=15: vec<=vec+1, counter reloaded to SETTLE_CYC, next state SETTLE.
REQ-019 CHECK with vec==15: next state DONE; vec does not wrap.
REQ-020 DONE: done=1 for exactly one cycle, pass<=(err_cnt==0) using the final count including the vec=15 result, next state IDLE.
REQ-021 Sweep length: start-accept cycle to done pulse = 16*(SETTLE_CYC+1)+1 cycles.
REQ-022 start asserted in SETTLE, CHECK or DONE is ignored, with no queuing.
REQ-023 err_cnt cannot exceed 16; 5 bits suffice, no saturation logic.
REQ-024 In IDLE, a..d hold the last driven vector (0 after reset); err_cnt, fail_vec, pass hold their values.

Reset
REQ-025 rst=1 at any edge forces IDLE, vec=0, a=b=c=d=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, counter=0.
REQ-026 rst overrides start in the same cycle; a sweep interrupted by reset is abandoned with no done pulse.

Verification
REQ-027 Correct chain model, SETTLE_CYC=1, start pulse at cycle T -> done at T+33, pass=1, err_cnt=0, fail_vec=0; a..d step through 0..15.
REQ-028 g stuck at 0 -> err_cnt=5 (vectors 0,2,6,10,14), fail_vec=0, pass=0.
REQ-029 e driven as (a|b) with f,g computed from the faulty e -> err_cnt=16, fail_vec=0, pass=0.
REQ-030 rst pulsed while vec=7 -> next cycle busy=0, a..d=0, err_cnt=0, no done; a new start runs a full 33-cycle sweep.
REQ-031 start re-pulsed mid-sweep and during the DONE cycle -> ignored, sweep timing unchanged; start one cycle after done is accepted.
REQ-032 SETTLE_CYC=3 with correct model -> done at T+65, pass=1; each vector held 4 cycles.
